// File: rtl/key_direction_queue.sv
// key_direction_queue: decodes PS/2 key events into per-player direction
// requests, buffers pending turns in a small per-player FIFO, and commits a
// turn when the engine confirms it. Reversals apply immediately. Also tracks
// held keys, a pause toggle and sticky per-player overflow flags.
module key_direction_queue #(
  parameter int          NUM_PLAYERS = 2,
  parameter int          QDEPTH      = 4,
  parameter logic [7:0]  P0_UP       = 8'h1D,
  parameter logic [7:0]  P0_DOWN     = 8'h1B,
  parameter logic [7:0]  P0_LEFT     = 8'h1C,
  parameter logic [7:0]  P0_RIGHT    = 8'h23,
  parameter logic [7:0]  P1_UP       = 8'h75,
  parameter logic [7:0]  P1_DOWN     = 8'h72,
  parameter logic [7:0]  P1_LEFT     = 8'h6B,
  parameter logic [7:0]  P1_RIGHT    = 8'h74,
  parameter logic [7:0]  PAUSE_KEY   = 8'h4D
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_valid,
  input  logic                       ext,
  input  logic [7:0]                 keycode,
  input  logic                       make,
  input  logic [NUM_PLAYERS-1:0]     turn_ok,
  output logic [2*NUM_PLAYERS-1:0]   direction,
  output logic [2*NUM_PLAYERS-1:0]   pending_dir,
  output logic [NUM_PLAYERS-1:0]     pending_valid,
  output logic [4*NUM_PLAYERS-1:0]   held,
  output logic                       paused,
  output logic [NUM_PLAYERS-1:0]     overflow
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  // Registered state
  logic [NUM_PLAYERS-1:0][1:0]             dir_q, dir_d;
  logic [NUM_PLAYERS-1:0][QDEPTH-1:0][1:0] mem_q, mem_d;
  logic [NUM_PLAYERS-1:0][PW-1:0]          rd_q, rd_d, wr_q, wr_d;
  logic [NUM_PLAYERS-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [NUM_PLAYERS-1:0][3:0]             held_q, held_d;
  logic [NUM_PLAYERS-1:0]                  ov_q, ov_d;
  logic                                    paused_q, paused_d;

  // Decoded key event (sized for two players regardless of NUM_PLAYERS)
  logic [1:0]      hit;
  logic [1:0][1:0] kdir;
  logic            pause_hit;

  // Per-player event qualifiers
  logic [NUM_PLAYERS-1:0] ev, flip, pop, dup, enq;

  // Decode the incoming scan event into a player/direction or the pause key.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    hit       = '0;
    kdir      = '0;
    pause_hit = 1'b0;
    if (key_valid) begin
      if (!ext) begin
        case (keycode)
          P0_UP:     begin hit[0] = 1'b1; kdir[0] = D_UP;    end
          P0_DOWN:   begin hit[0] = 1'b1; kdir[0] = D_DOWN;  end
          P0_LEFT:   begin hit[0] = 1'b1; kdir[0] = D_LEFT;  end
          P0_RIGHT:  begin hit[0] = 1'b1; kdir[0] = D_RIGHT; end
          PAUSE_KEY: pause_hit = 1'b1;
          default:   ;
        endcase
      end else if (NUM_PLAYERS > 1) begin
        case (keycode)
          P1_UP:    begin hit[1] = 1'b1; kdir[1] = D_UP;    end
          P1_DOWN:  begin hit[1] = 1'b1; kdir[1] = D_DOWN;  end
          P1_LEFT:  begin hit[1] = 1'b1; kdir[1] = D_LEFT;  end
          P1_RIGHT: begin hit[1] = 1'b1; kdir[1] = D_RIGHT; end
          default:  ;
        endcase
      end
    end
  end

  // Next-state logic: held tracking, reversal, dedup, enqueue/pop, overflow.
  always_comb begin
    dir_d    = dir_q;
    mem_d    = mem_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    held_d   = held_q;
    ov_d     = ov_q;
    paused_d = paused_q ^ (pause_hit & make);
    ev       = '0;
    flip     = '0;
    pop      = '0;
    dup      = '0;
    enq      = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      // Held flags follow make/break even while paused.
      if (hit[p]) held_d[p][kdir[p]] = make;

      ev[p]   = hit[p] & make & ~paused_q;
      flip[p] = ev[p] & (kdir[p] == (dir_q[p] ^ 2'b01));
      dup[p]  = (kdir[p] == dir_q[p]) ||
                ((cnt_q[p] != '0) && (kdir[p] == mem_q[p][wr_q[p] - PW'(1)]));
      pop[p]  = turn_ok[p] & ~paused_q & (cnt_q[p] != '0) & ~flip[p];
      enq[p]  = ev[p] & ~flip[p] & ~dup[p];

      if (flip[p]) begin
        // Reversal commits at once and discards any queued turns.
        dir_d[p] = kdir[p];
        rd_d[p]  = '0;
        wr_d[p]  = '0;
        cnt_d[p] = '0;
      end else begin
        if (pop[p]) begin
          dir_d[p] = mem_q[p][rd_q[p]];
          rd_d[p]  = rd_q[p] + PW'(1);
        end
        if (enq[p]) begin
          mem_d[p][wr_q[p]] = kdir[p];
          wr_d[p]           = wr_q[p] + PW'(1);
          if (!pop[p]) begin
            if (cnt_q[p] == FULL) begin
              // Full with no pop: the oldest entry is overwritten in place.
              rd_d[p] = rd_q[p] + PW'(1);
              ov_d[p] = 1'b1;
            end else begin
              cnt_d[p] = cnt_q[p] + CW'(1);
            end
          end
        end else if (pop[p]) begin
          cnt_d[p] = cnt_q[p] - CW'(1);
        end
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      held_q   <= '0;
      ov_q     <= '0;
      paused_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
      dir_q    <= dir_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      held_q   <= held_d;
      ov_q     <= ov_d;
      paused_q <= paused_d;
    end
  end

  // FIFO storage; contents are only observed through the count-gated head.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an empty count makes stale entries invisible.
    mem_q <= mem_d;
  end

  // Present the FIFO head, forced to zero when the FIFO is empty.
  always_comb begin
    pending_dir   = '0;
    pending_valid = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      pending_valid[p] = (cnt_q[p] != '0);
      if (cnt_q[p] != '0) pending_dir[2*p +: 2] = mem_q[p][rd_q[p]];
    end
  end

  assign direction = dir_q;
  assign held      = held_q;
  assign paused    = paused_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_key_direction_queue.sv
// Self-checking bench for key_direction_queue: a driver applies directed and
// random key/turn_ok stimulus, updates a queue-based reference model and
// pushes the expected outputs into a scoreboard; a monitor pops and compares.
module tb_key_direction_queue;

  localparam int NP = 2;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_valid = 1'b0;
  logic          ext = 1'b0;
  logic [7:0]    keycode = 8'h00;
  logic          make = 1'b0;
  logic [NP-1:0] turn_ok = '0;
  logic [2*NP-1:0] direction, pending_dir;
  logic [NP-1:0]   pending_valid, overflow;
  logic [4*NP-1:0] held;
  logic            paused;

  key_direction_queue #(.NUM_PLAYERS(NP), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .ext(ext), .keycode(keycode),
    .make(make), .turn_ok(turn_ok), .direction(direction),
    .pending_dir(pending_dir), .pending_valid(pending_valid), .held(held),
    .paused(paused), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*NP-1:0] dir;
    logic [2*NP-1:0] pdir;
    logic [NP-1:0]   pv;
    logic [4*NP-1:0] held;
    logic            paused;
    logic [NP-1:0]   ov;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  logic [1:0] m_dir [NP];
  logic [1:0] mq [NP][$];
  logic [3:0] m_held [NP];
  logic       m_ov [NP];
  logic       m_paused;

  // Returns -1 for unmapped, 8 for pause, otherwise player*4 + direction.
  function automatic int decode(input logic e, input logic [7:0] kc);
    if (!e) begin
      case (kc)
        8'h1D: return 0;
        8'h1B: return 1;
        8'h1C: return 2;
        8'h23: return 3;
        8'h4D: return 8;
        default: return -1;
      endcase
    end else begin
      case (kc)
        8'h75: return 4;
        8'h72: return 5;
        8'h6B: return 6;
        8'h74: return 7;
        default: return -1;
      endcase
    end
  endfunction

  task automatic model_step(input logic r, input logic kv, input logic e,
                            input logic [7:0] kc, input logic mk,
                            input logic [NP-1:0] tok);
    int code, kp;
    logic [1:0] d, olddir;
    logic was_paused, tail_dup, ev;
    if (r) begin
      for (int p = 0; p < NP; p++) begin
        m_dir[p] = 2'd0; mq[p].delete(); m_held[p] = 4'h0; m_ov[p] = 1'b0;
      end
      m_paused = 1'b0;
      return;
    end
    code = kv ? decode(e, kc) : -1;
    kp   = (code >= 0 && code < 8) ? code / 4 : -1;
    d    = 2'(code % 4);
    was_paused = m_paused;
    if (code == 8 && mk) m_paused = ~m_paused;
    for (int p = 0; p < NP; p++) begin
      ev = (kp == p) && mk && !was_paused;
      if (kp == p) m_held[p][d] = mk;
      if (ev && d == (m_dir[p] ^ 2'b01)) begin
        m_dir[p] = d;
        mq[p].delete();
      end else begin
        olddir   = m_dir[p];
        tail_dup = (mq[p].size() > 0) && (mq[p][$] == d);
        if (tok[p] && !was_paused && mq[p].size() > 0) m_dir[p] = mq[p].pop_front();
        if (ev && !(d == olddir || tail_dup)) begin
          if (mq[p].size() == QD) begin
            void'(mq[p].pop_front());
            m_ov[p] = 1'b1;
          end
          mq[p].push_back(d);
        end
      end
    end
  endtask

  function automatic exp_t snapshot();
    exp_t s;
    s = '0;
    for (int p = 0; p < NP; p++) begin
      s.dir[2*p +: 2]  = m_dir[p];
      s.pdir[2*p +: 2] = (mq[p].size() > 0) ? mq[p][0] : 2'd0;
      s.pv[p]          = mq[p].size() > 0;
      s.held[4*p +: 4] = m_held[p];
      s.ov[p]          = m_ov[p];
    end
    s.paused = m_paused;
    return s;
  endfunction

  // Driver: apply one cycle of inputs, advance the model, queue expectation.
  task automatic step(input logic r, input logic kv, input logic e,
                      input logic [7:0] kc, input logic mk, input logic [NP-1:0] tok);
    @(negedge clk);
    rst = r; key_valid = kv; ext = e; keycode = kc; make = mk; turn_ok = tok;
    model_step(r, kv, e, kc, mk, tok);
    sb.push_back(snapshot());
  endtask

  task automatic key(input logic e, input logic [7:0] kc, input logic mk);
    step(1'b0, 1'b1, e, kc, mk, '0);
  endtask

  task automatic idle(input logic [NP-1:0] tok);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, tok);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  // Monitor: one expected snapshot per clock edge, compared just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        check("direction",     32'(direction),     32'(e.dir));
        check("pending_dir",   32'(pending_dir),   32'(e.pdir));
        check("pending_valid", 32'(pending_valid), 32'(e.pv));
        check("held",          32'(held),          32'(e.held));
        check("paused",        32'(paused),        32'(e.paused));
        check("overflow",      32'(overflow),      32'(e.ov));
      end
    end
  end

  logic [8:0] klist [10] = '{9'h01D, 9'h01B, 9'h01C, 9'h023,
                             9'h175, 9'h172, 9'h16B, 9'h174,
                             9'h075, 9'h11D};

  initial begin
    logic [8:0] k;
    logic [NP-1:0] tok;
    // Reset
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, '0);
    // Queued turn then accept
    key(1'b0, 8'h1C, 1'b1);
    idle(2'b01);
    idle('0);
    // Reversal with RIGHT queued
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, '0);
    key(1'b0, 8'h23, 1'b1);
    key(1'b0, 8'h1B, 1'b1);
    // Reversal with simultaneous turn_ok
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, '0);
    key(1'b0, 8'h23, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h1B, 1'b1, 2'b01);
    // Overflow and dedup on player 1
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, '0);
    key(1'b1, 8'h74, 1'b1);
    key(1'b1, 8'h74, 1'b1);
    key(1'b1, 8'h6B, 1'b1);
    key(1'b1, 8'h74, 1'b1);
    key(1'b1, 8'h6B, 1'b1);
    key(1'b1, 8'h74, 1'b1);
    key(1'b1, 8'h6B, 1'b1);
    // Full FIFO with pop and enqueue in the same cycle
    step(1'b0, 1'b1, 1'b1, 8'h72, 1'b1, 2'b10);
    idle(2'b10);
    // Pause: make/turn_ok ignored, held still tracked
    key(1'b0, 8'h4D, 1'b1);
    key(1'b0, 8'h4D, 1'b0);
    key(1'b0, 8'h1C, 1'b1);
    idle(2'b11);
    key(1'b0, 8'h1C, 1'b0);
    key(1'b0, 8'h4D, 1'b1);
    // Ext mismatch and key_valid=0
    key(1'b0, 8'h75, 1'b1);
    key(1'b1, 8'h1D, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h1C, 1'b1, '0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      k = klist[$urandom_range(0, 9)];
      if ($urandom_range(0, 39) == 0) k = 9'h04D;
      tok = '0;
      for (int p = 0; p < NP; p++) tok[p] = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, k[8], k[7:0],
           $urandom_range(0, 3) != 0, tok);
    end
    idle('0);
    // Drain: bounded wait for the monitor to consume all expectations
    repeat (4) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
